// File: rtl/sifting_round_ctrl.sv
// Sequences one Alice/Bob sifting round: starts both engines, collects finish, write and
// visibility events under a timeout, checks the round and offers a valid/ready summary.
module sifting_round_ctrl #(
  parameter int NVIS_WIDTH     = 16,
  parameter int CNT_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int TO_WIDTH       = 22
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_switch,
  output logic                  A_sift_start,
  output logic                  B_sift_start,
  input  logic                  A_sifting_finish,
  input  logic                  B_sifting_finish,
  input  logic                  Asiftedkey_we,
  input  logic                  Bsiftedkey_we,
  input  logic                  A_visibility_valid,
  input  logic [NVIS_WIDTH-1:0] nvis,
  output logic                  sum_valid,
  input  logic                  sum_ready,
  output logic [NVIS_WIDTH-1:0] sum_nvis,
  output logic [CNT_WIDTH-1:0]  sum_A_words,
  output logic [CNT_WIDTH-1:0]  sum_B_words,
  output logic                  round_error,
  output logic [1:0]            err_code,
  output logic                  busy
);

  // state | meaning
  // IDLE  | waiting for a start_switch rising edge; last summary held
  // START | one-cycle start pulse to both sifting engines
  // RUN   | collecting finish pulses, write strobes and visibility; timeout armed
  // CHECK | one-cycle round consistency check
  // DONE  | summary presented until sum_ready
  // ERR   | round aborted, err_code held until the next start edge
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_RUN   = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  localparam logic [TO_WIDTH-1:0]  TO_LOAD = TO_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t                  state, state_nxt;
  logic                    start_q, start_rise;
  logic                    a_fin, b_fin, vis_got;
  logic                    both_done, to_tc, round_clr;
  logic [TO_WIDTH-1:0]     to_cnt;
  logic [1:0]              err_q, err_nxt;
  logic [NVIS_WIDTH-1:0]   nvis_q;
  logic [CNT_WIDTH-1:0]    a_cnt, b_cnt;

  assign start_rise = start_switch & ~start_q;
  assign both_done  = (a_fin | A_sifting_finish) & (b_fin | B_sifting_finish);
  // Timeout runs as a down-counter loaded at round start; zero is the last RUN cycle.
  assign to_tc      = (to_cnt == '0);
  assign round_clr  = (state_nxt == S_START);

  always_comb begin
    state_nxt = state;
    err_nxt   = err_q;
    case (state)
      S_IDLE, S_ERR: begin
        if (start_rise) begin
          state_nxt = S_START;
          err_nxt   = 2'b00;
        end
      end
      S_START: state_nxt = S_RUN;
      S_RUN: begin
        if (both_done) begin
          state_nxt = S_CHECK;
        end else if (to_tc) begin
          state_nxt = S_ERR;
          err_nxt   = 2'b11;
        end
      end
      S_CHECK: begin
        if (a_cnt != b_cnt) begin
          state_nxt = S_ERR;
          err_nxt   = 2'b01;
        end else if (!vis_got) begin
          state_nxt = S_ERR;
          err_nxt   = 2'b10;
        end else begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (sum_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      start_q <= 1'b1;
      a_fin   <= 1'b0;
      b_fin   <= 1'b0;
      vis_got <= 1'b0;
      to_cnt  <= '0;
      err_q   <= 2'b00;
      nvis_q  <= '0;
      a_cnt   <= '0;
      b_cnt   <= '0;
    end else begin
      state   <= state_nxt;
      start_q <= start_switch;
      err_q   <= err_nxt;
      if (round_clr) begin
        a_fin   <= 1'b0;
        b_fin   <= 1'b0;
        vis_got <= 1'b0;
        nvis_q  <= '0;
        a_cnt   <= '0;
        b_cnt   <= '0;
        to_cnt  <= TO_LOAD;
      end else if (state == S_RUN) begin
        if (A_sifting_finish) a_fin <= 1'b1;
        if (B_sifting_finish) b_fin <= 1'b1;
        if (Asiftedkey_we && (a_cnt != CNT_MAX)) a_cnt <= a_cnt + 1'b1;
        if (Bsiftedkey_we && (b_cnt != CNT_MAX)) b_cnt <= b_cnt + 1'b1;
        if (A_visibility_valid && !vis_got) begin
          nvis_q  <= nvis;
          vis_got <= 1'b1;
        end
        if (!to_tc) to_cnt <= to_cnt - 1'b1;
      end
    end
  end

  assign A_sift_start = (state == S_START);
  assign B_sift_start = (state == S_START);
  assign sum_valid    = (state == S_DONE);
  assign round_error  = (state == S_ERR);
  assign busy         = (state != S_IDLE) && (state != S_ERR);
  assign err_code     = err_q;
  assign sum_nvis     = nvis_q;
  assign sum_A_words  = a_cnt;
  assign sum_B_words  = b_cnt;

endmodule

// File: tb/tb_sifting_round_ctrl.sv
// Scoreboard bench for sifting_round_ctrl: round outcomes come from a round-level model
// and are checked by a monitor at each summary handshake or error entry.
module tb_sifting_round_ctrl;

  localparam int NW = 16;

  typedef struct {
    logic [1:0]    code;
    logic [NW-1:0] nv;
    logic [NW-1:0] a;
    logic [NW-1:0] b;
  } exp_t;

  logic clk, rst_n, start_switch;
  logic a_fin, b_fin, a_we, b_we, vis_valid, sum_ready;
  logic [NW-1:0] nvis;

  logic A_sift_start, B_sift_start, sum_valid, round_error, busy;
  logic [NW-1:0] sum_nvis, sum_A_words, sum_B_words;
  logic [1:0] err_code;

  logic t_A_sift_start, t_B_sift_start, t_sum_valid, t_round_error, t_busy;
  logic [NW-1:0] t_sum_nvis, t_sum_A_words, t_sum_B_words;
  logic [1:0] t_err_code;

  exp_t sb[$];
  int n_pass = 0;
  int n_tot  = 0;
  int a_pulses = 0;
  int b_pulses = 0;
  int cyc_cnt = 0;

  sifting_round_ctrl #(.NVIS_WIDTH(NW), .CNT_WIDTH(NW), .TIMEOUT_CYCLES(1000), .TO_WIDTH(10)) dut (
    .clk(clk), .rst_n(rst_n), .start_switch(start_switch),
    .A_sift_start(A_sift_start), .B_sift_start(B_sift_start),
    .A_sifting_finish(a_fin), .B_sifting_finish(b_fin),
    .Asiftedkey_we(a_we), .Bsiftedkey_we(b_we),
    .A_visibility_valid(vis_valid), .nvis(nvis),
    .sum_valid(sum_valid), .sum_ready(sum_ready), .sum_nvis(sum_nvis),
    .sum_A_words(sum_A_words), .sum_B_words(sum_B_words),
    .round_error(round_error), .err_code(err_code), .busy(busy)
  );

  sifting_round_ctrl #(.NVIS_WIDTH(NW), .CNT_WIDTH(NW), .TIMEOUT_CYCLES(64), .TO_WIDTH(22)) dut_to (
    .clk(clk), .rst_n(rst_n), .start_switch(start_switch),
    .A_sift_start(t_A_sift_start), .B_sift_start(t_B_sift_start),
    .A_sifting_finish(a_fin), .B_sifting_finish(b_fin),
    .Asiftedkey_we(a_we), .Bsiftedkey_we(b_we),
    .A_visibility_valid(vis_valid), .nvis(nvis),
    .sum_valid(t_sum_valid), .sum_ready(sum_ready), .sum_nvis(t_sum_nvis),
    .sum_A_words(t_sum_A_words), .sum_B_words(t_sum_B_words),
    .round_error(t_round_error), .err_code(t_err_code), .busy(t_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_tot);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Round-level reference: timeout dominates, then count mismatch, then missing visibility.
  function automatic exp_t model(input int na, input int nb, input bit vis, input bit timeout,
                                 input logic [NW-1:0] nv);
    exp_t e;
    if (timeout)      e.code = 2'b11;
    else if (na != nb) e.code = 2'b01;
    else if (!vis)     e.code = 2'b10;
    else               e.code = 2'b00;
    e.nv = vis ? nv : '0;
    e.a  = NW'((na > 65535) ? 65535 : na);
    e.b  = NW'((nb > 65535) ? 65535 : nb);
    return e;
  endfunction

  // Monitor: pops one expectation per summary handshake or per entry into the error state.
  initial begin
    exp_t e;
    logic err_prev;
    err_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        err_prev = 1'b0;
      end else begin
        if (A_sift_start) a_pulses++;
        if (B_sift_start) b_pulses++;
        if (sum_valid && sum_ready) begin
          if (sb.size() == 0) chk("sb_unexpected_summary", 32'(sb.size()), 1);
          else begin
            e = sb.pop_front();
            chk("sum_err_code", 32'(err_code), 32'(e.code));
            chk("sum_nvis", 32'(sum_nvis), 32'(e.nv));
            chk("sum_A_words", 32'(sum_A_words), 32'(e.a));
            chk("sum_B_words", 32'(sum_B_words), 32'(e.b));
          end
        end
        if (round_error && !err_prev) begin
          if (sb.size() == 0) chk("sb_unexpected_error", 32'(sb.size()), 1);
          else begin
            e = sb.pop_front();
            chk("error_code", 32'(err_code), 32'(e.code));
          end
        end
        err_prev = round_error;
      end
    end
  end

  task automatic start_edge();
    start_switch = 1'b0;
    tick();
    start_switch = 1'b1;
    tick();
    chk("start_pulse_A", 32'(A_sift_start), 1);
    chk("start_pulse_B", 32'(B_sift_start), 1);
    chk("start_clears_error", 32'(round_error), 0);
    chk("start_clears_code", 32'(err_code), 0);
    chk("start_clears_count", 32'(sum_A_words), 0);
    chk("start_busy", 32'(busy), 1);
    tick();
    chk("run_no_start_pulse", 32'(A_sift_start), 0);
  endtask

  // mode 0: A finishes, B 5 cycles later; 1: both in one cycle; 2: only A (timeout)
  task automatic run_round(input int na, input int nb, input bit vis, input logic [NW-1:0] nv,
                           input int mode, input bit fin_strobe, input bit restart, input int hold);
    exp_t e;
    int ia, ib, c, pa, pb, rs;
    e = model(fin_strobe ? na + 1 : na, fin_strobe ? nb + 1 : nb, vis, mode == 2, nv);
    sb.push_back(e);
    pa = a_pulses;
    pb = b_pulses;
    start_edge();
    rs = cyc_cnt;
    ia = 0; ib = 0; c = 0;
    while (ia < na || ib < nb || c < 4) begin
      a_we = (ia < na) && ($urandom_range(3) != 0);
      b_we = (ib < nb) && ($urandom_range(3) != 0);
      if (a_we) ia++;
      if (b_we) ib++;
      vis_valid = vis && (c == 1 || c == 3);
      nvis = (c == 1) ? nv : NW'($urandom);
      if (restart && c == 2) start_switch = 1'b0;
      if (restart && c == 3) start_switch = 1'b1;
      tick();
      c++;
    end
    a_we = 1'b0; b_we = 1'b0; vis_valid = 1'b0;
    if (mode == 1) begin
      a_fin = 1'b1;
      b_fin = 1'b1;
    end else begin
      a_fin = 1'b1;
      tick();
      a_fin = 1'b0;
      if (mode == 0) begin
        repeat (4) tick();
        b_fin = 1'b1;
      end
    end
    if (fin_strobe) begin
      a_we = 1'b1;
      b_we = 1'b1;
    end
    if (mode != 2) begin
      tick();
      a_fin = 1'b0; b_fin = 1'b0; a_we = 1'b0; b_we = 1'b0;
      chk("check_cycle_no_valid", 32'(sum_valid), 0);
      tick();
      if (e.code == 2'b00) begin
        chk("valid_latency", 32'(sum_valid), 1);
        for (int h = 0; h < hold; h++) begin
          chk("hold_valid", 32'(sum_valid), 1);
          chk("hold_nvis", 32'(sum_nvis), 32'(e.nv));
          chk("hold_A_words", 32'(sum_A_words), 32'(e.a));
          chk("hold_B_words", 32'(sum_B_words), 32'(e.b));
          tick();
        end
        sum_ready = 1'b1;
        tick();
        sum_ready = 1'b0;
        chk("valid_drop", 32'(sum_valid), 0);
        chk("idle_not_busy", 32'(busy), 0);
      end else begin
        chk("err_latency", 32'(round_error), 1);
        chk("err_latency_code", 32'(err_code), 32'(e.code));
        chk("err_not_busy", 32'(busy), 0);
      end
    end else begin
      while (cyc_cnt - rs < 63) tick();
      chk("timeout_not_early", 32'(t_round_error), 0);
      tick();
      chk("timeout_exact", 32'(t_round_error), 1);
      chk("timeout_code", 32'(t_err_code), 3);
      c = 0;
      while (!round_error && c < 1200) begin
        tick();
        c++;
      end
      chk("timeout_main", 32'(round_error), 1);
    end
    chk("start_pulses_A", a_pulses - pa, 1);
    chk("start_pulses_B", b_pulses - pb, 1);
  endtask

  initial begin
    int na, nb, m;
    bit vis_r, fs_r;
    int pa;
    rst_n = 1'b0; start_switch = 1'b0; a_fin = 1'b0; b_fin = 1'b0;
    a_we = 1'b0; b_we = 1'b0; vis_valid = 1'b0; sum_ready = 1'b0; nvis = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 0);
    chk("reset_valid", 32'(sum_valid), 0);
    chk("reset_start", 32'(A_sift_start), 0);
    chk("reset_err", 32'(err_code), 0);
    chk("reset_nvis", 32'(sum_nvis), 0);
    rst_n = 1'b1;
    tick();

    run_round(100, 100, 1'b1, 16'd37, 0, 1'b0, 1'b0, 0);
    run_round(8, 8, 1'b1, 16'h1234, 1, 1'b0, 1'b0, 10);
    run_round(50, 49, 1'b1, 16'd5, 0, 1'b0, 1'b0, 0);
    run_round(10, 10, 1'b1, 16'd9, 2, 1'b0, 1'b0, 0);
    run_round(5, 5, 1'b0, 16'd0, 1, 1'b0, 1'b1, 0);
    run_round(6, 6, 1'b1, 16'hBEEF, 1, 1'b1, 1'b0, 2);

    for (int r = 0; r < 12; r++) begin
      na = $urandom_range(40, 1);
      nb = ($urandom_range(3) == 0) ? na + $urandom_range(2, 1) : na;
      vis_r = ($urandom_range(4) != 0);
      fs_r  = ($urandom_range(1) == 1);
      m = $urandom_range(1);
      run_round(na, nb, vis_r, NW'($urandom), m, fs_r, 1'b0, $urandom_range(3));
    end

    start_edge();
    a_we = 1'b1;
    repeat (3) tick();
    a_we = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("async_reset_busy", 32'(busy), 0);
    chk("async_reset_words", 32'(sum_A_words), 0);
    chk("async_reset_valid", 32'(sum_valid), 0);
    chk("async_reset_error", 32'(round_error), 0);
    pa = a_pulses;
    tick();
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    chk("held_switch_no_start", a_pulses - pa, 0);
    chk("held_switch_idle", 32'(busy), 0);
    run_round(12, 12, 1'b1, 16'd77, 0, 1'b0, 1'b0, 1);

    repeat (5) tick();
    chk("scoreboard_drained", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
